pll_ce_gen: RTL and testbench

- Parametrised, fully synchronous successor to the fixed single-output VGA pixel-clock PLL.
- Generates NUM_CH independent fractional clock-enable streams and ~50% square-wave strobes from refclk, using per-channel phase accumulators.
- Each channel's frequency is reprogrammable at run time through a valid/ready config port, and each channel has its own settle/lock indication.
- Used to derive pixel, audio and peripheral rates inside the refclk domain without extra PLL instances.

---
 rtl/pll_ce_gen.sv | 134 +++++++++++++
 tb/tb_pll_ce_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_ce_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// each with its own settle counter, lock flag and run-time reprogrammable increment.
module pll_ce_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_INC = 43253,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  // Config handshake: a write transfers on a refclk edge where cfg_valid and
  // cfg_ready are both 1; cfg_valid may be held without a combinational path
  // from it to cfg_ready, and the new setting takes effect from the next edge.
  input  logic                  cfg_valid,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [ACC_W-1:0]      cfg_inc,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic [NUM_CH-1:0]     outclk_en,
  output logic [NUM_CH-1:0]     outclk,
  output logic [NUM_CH-1:0]     locked,
  output logic                  locked_all,
  output logic [2*NUM_CH-1:0]   ch_state
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_LOCKED   = 2'd2
  } ch_state_t;

  ch_state_t          state_q [NUM_CH];
  ch_state_t          state_d [NUM_CH];
  logic [ACC_W-1:0]   acc_q   [NUM_CH];
  logic [ACC_W-1:0]   acc_d   [NUM_CH];
  logic [ACC_W-1:0]   inc_q   [NUM_CH];
  logic [ACC_W-1:0]   inc_d   [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [ACC_W:0]     sum     [NUM_CH];
  logic [NUM_CH-1:0]  en_q;
  logic [NUM_CH-1:0]  en_d;
  logic [NUM_CH-1:0]  locked_d;
  logic               wr_hit;
  logic               wr_bad;
  logic               err_q;
  logic               ready_q;
  logic               locked_all_q;

  always_comb begin
    wr_hit   = cfg_valid & ready_q;
    wr_bad   = wr_hit & (32'(cfg_ch) >= NUM_CH);
    en_d     = '0;
    locked_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]     = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      state_d[i] = state_q[i];
      acc_d[i]   = acc_q[i];
      inc_d[i]   = inc_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_SETTLE: begin
          acc_d[i] = '0;
          if (cnt_q[i] == CNT_W'(LOCK_CYCLES - 1)) begin
            state_d[i] = ST_LOCKED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          en_d[i]  = sum[i][ACC_W];
          acc_d[i] = sum[i][ACC_W-1:0];
        end
        default: begin
          state_d[i] = ST_DISABLED;
          acc_d[i]   = '0;
        end
      endcase
      // A write wins over a same-cycle carry: the pulse is dropped.
      if (wr_hit && !wr_bad && (32'(cfg_ch) == i)) begin
        inc_d[i]   = cfg_inc;
        acc_d[i]   = '0;
        cnt_d[i]   = '0;
        en_d[i]    = 1'b0;
        state_d[i] = (cfg_inc != '0) ? ST_SETTLE : ST_DISABLED;
      end
      locked_d[i] = (state_d[i] == ST_LOCKED);
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_SETTLE;
        acc_q[i]   <= '0;
        inc_q[i]   <= ACC_W'(DEFAULT_INC);
        cnt_q[i]   <= '0;
      end
      en_q         <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      locked_all_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        acc_q[i]   <= acc_d[i];
        inc_q[i]   <= inc_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      en_q         <= en_d;
      err_q        <= wr_bad;
      ready_q      <= 1'b1;
      locked_all_q <= &locked_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      locked[i]         = (state_q[i] == ST_LOCKED);
      outclk[i]         = locked[i] & acc_q[i][ACC_W-1];
      ch_state[2*i +: 2] = state_q[i];
    end
  end

  assign outclk_en  = en_q;
  assign cfg_ready  = ready_q;
  assign cfg_err    = err_q;
  assign locked_all = locked_all_q;

endmodule

// File: tb/tb_pll_ce_gen.sv
// Directed bench for pll_ce_gen: a 2-channel instance for the main function and a
// 3-channel instance whose 2-bit channel index can address an out-of-range channel.
module tb_pll_ce_gen;

  localparam int DEF_INC = 43253;

  logic        refclk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  int          a_ch, b_ch;
  logic [15:0] a_inc, b_inc;

  logic        a_ready, a_err, a_lall;
  logic [1:0]  a_en, a_oclk, a_lock;
  logic [3:0]  a_state;
  logic        b_ready, b_err, b_lall;
  logic [2:0]  b_en, b_oclk, b_lock;
  logic [5:0]  b_state;
  logic        a_cfg_ch;
  logic [1:0]  b_cfg_ch;

  assign a_cfg_ch = a_ch[0];
  assign b_cfg_ch = b_ch[1:0];

  always #5 refclk = ~refclk;

  pll_ce_gen #(.NUM_CH(2), .ACC_W(16), .LOCK_CYCLES(16), .DEFAULT_INC(DEF_INC)) dut_a (
    .refclk(refclk), .rst(rst), .cfg_valid(a_valid), .cfg_ch(a_cfg_ch), .cfg_inc(a_inc),
    .cfg_ready(a_ready), .cfg_err(a_err), .outclk_en(a_en), .outclk(a_oclk),
    .locked(a_lock), .locked_all(a_lall), .ch_state(a_state)
  );

  pll_ce_gen #(.NUM_CH(3), .ACC_W(16), .LOCK_CYCLES(16), .DEFAULT_INC(DEF_INC)) dut_b (
    .refclk(refclk), .rst(rst), .cfg_valid(b_valid), .cfg_ch(b_cfg_ch), .cfg_inc(b_inc),
    .cfg_ready(b_ready), .cfg_err(b_err), .outclk_en(b_en), .outclk(b_oclk),
    .locked(b_lock), .locked_all(b_lall), .ch_state(b_state)
  );

  // Reference model, per instance d and channel c (state: 0 disabled, 1 settle, 2 locked)
  int          m_st  [2][3];
  int          m_cnt [2][3];
  logic [15:0] m_acc [2][3];
  logic [15:0] m_inc [2][3];
  logic        m_en  [2][3];
  logic        m_rdy [2];
  logic        m_err [2];
  int          nch   [2] = '{2, 3};

  logic [11:0] exp_q_a[$];
  logic [11:0] exp_q_b[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d, input logic r, input logic v, input int ch,
                            input logic [15:0] inc);
    logic        hit;
    logic [16:0] s;
    if (!r) begin
      for (int c = 0; c < 3; c++) begin
        m_st[d][c] = 1; m_cnt[d][c] = 0; m_acc[d][c] = '0;
        m_inc[d][c] = 16'(DEF_INC); m_en[d][c] = 1'b0;
      end
      m_rdy[d] = 1'b0;
      m_err[d] = 1'b0;
    end else begin
      hit      = v && m_rdy[d];
      m_err[d] = hit && (ch >= nch[d]);
      for (int c = 0; c < nch[d]; c++) begin
        m_en[d][c] = 1'b0;
        if (m_st[d][c] == 2) begin
          s = {1'b0, m_acc[d][c]} + {1'b0, m_inc[d][c]};
          m_en[d][c]  = s[16];
          m_acc[d][c] = s[15:0];
        end else begin
          m_acc[d][c] = '0;
          if (m_st[d][c] == 1) begin
            if (m_cnt[d][c] == 15) begin m_st[d][c] = 2; m_cnt[d][c] = 0; end
            else m_cnt[d][c]++;
          end
        end
        if (hit && ch == c) begin
          m_inc[d][c] = inc; m_acc[d][c] = '0; m_cnt[d][c] = 0; m_en[d][c] = 1'b0;
          m_st[d][c] = (inc != 0) ? 1 : 0;
        end
      end
      m_rdy[d] = 1'b1;
    end
  endtask

  function automatic logic [11:0] model_word(input int d);
    logic [11:0] w;
    logic        lall;
    w = '0;
    lall = 1'b1;
    for (int c = 0; c < nch[d]; c++) begin
      w[c]     = m_en[d][c];
      w[3 + c] = (m_st[d][c] == 2) && m_acc[d][c][15];
      w[6 + c] = (m_st[d][c] == 2);
      lall     = lall & (m_st[d][c] == 2);
    end
    w[9]  = lall;
    w[10] = m_err[d];
    w[11] = m_rdy[d];
    return w;
  endfunction

  function automatic logic [11:0] word_a();
    return {a_ready, a_err, a_lall, 1'b0, a_lock, 1'b0, a_oclk, 1'b0, a_en};
  endfunction

  function automatic logic [11:0] word_b();
    return {b_ready, b_err, b_lall, b_lock, b_oclk, b_en};
  endfunction

  // One clock: push the model's prediction, let the edge happen, pop and compare.
  task automatic step();
    model_step(0, rst, a_valid, a_ch, a_inc);
    model_step(1, rst, b_valid, b_ch, b_inc);
    exp_q_a.push_back(model_word(0));
    exp_q_b.push_back(model_word(1));
    @(posedge refclk);
    @(negedge refclk);
    check("cycle_a", 32'(word_a()), 32'(exp_q_a.pop_front()));
    check("cycle_b", 32'(word_b()), 32'(exp_q_b.pop_front()));
  endtask

  task automatic write_a(input int ch, input logic [15:0] inc);
    a_valid = 1'b1; a_ch = ch; a_inc = inc;
    step();
    a_valid = 1'b0;
  endtask

  int cnt0, cnt1, acc_bits;

  initial begin
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_ch = 0; b_ch = 0; a_inc = '0; b_inc = '0;
    @(negedge refclk);

    // Reset state
    step(); step();
    check("reset_outputs_a", 32'(word_a()), 32'h0);
    rst = 1'b1;

    // Lock exactly 16 edges after release
    for (int k = 0; k < 15; k++) step();
    check("not_locked_at_15", 32'({a_lall, a_lock}), 32'h0);
    step();
    check("locked_at_16", 32'({a_lall, a_lock}), 32'h7);

    // Pulse count over 2^16 locked cycles
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 65536; k++) begin
      step();
      cnt0 += int'(a_en[0]);
      cnt1 += int'(a_en[1]);
    end
    check("pulses_ch0", 32'(cnt0), 32'(DEF_INC));
    check("pulses_ch1", 32'(cnt1), 32'(DEF_INC));

    // ch0 inc=32768: unlock, relock after 16, pulse every 2nd cycle
    write_a(0, 16'd32768);
    check("ch0_unlock", 32'({a_lall, a_lock[0]}), 32'h0);
    for (int k = 0; k < 15; k++) step();
    check("ch0_still_settling", 32'(a_lock[0]), 32'h0);
    step();
    check("ch0_relock", 32'(a_lock[0]), 32'h1);
    cnt0 = 0;
    for (int k = 0; k < 20; k++) begin step(); cnt0 += int'(a_en[0]); end
    check("ch0_half_rate", 32'(cnt0), 32'd10);

    // ch1 disabled for 1000 cycles, then inc=16384
    write_a(1, 16'd0);
    acc_bits = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      acc_bits += int'(a_en[1]) + int'(a_oclk[1]) + int'(a_lock[1]) + int'(a_lall);
    end
    check("ch1_disabled_quiet", 32'(acc_bits), 32'd0);
    write_a(1, 16'd16384);
    for (int k = 0; k < 15; k++) step();
    check("ch1_settling", 32'(a_lock[1]), 32'h0);
    step();
    check("ch1_relock", 32'(a_lock[1]), 32'h1);
    cnt1 = 0;
    for (int k = 0; k < 40; k++) begin step(); cnt1 += int'(a_en[1]); end
    check("ch1_quarter_rate", 32'(cnt1), 32'd10);

    // Re-writes mid-settle restart the counter; same value still re-settles
    write_a(0, 16'd32768);
    for (int k = 0; k < 9; k++) step();
    write_a(0, 16'd12345);
    for (int k = 0; k < 4; k++) step();
    write_a(0, 16'd12345);
    acc_bits = 0;
    for (int k = 0; k < 15; k++) begin step(); acc_bits += int'(a_lock[0]); end
    check("ch0_no_early_lock", 32'(acc_bits), 32'd0);
    step();
    check("ch0_lock_after_rewrite", 32'(a_lock[0]), 32'h1);
    for (int k = 0; k < 10; k++) step();

    // Out-of-range channel on the 3-channel instance
    b_valid = 1'b1; b_ch = 3; b_inc = 16'd100;
    step();
    b_valid = 1'b0;
    check("cfg_err_pulse", 32'(b_err), 32'h1);
    step();
    check("cfg_err_clear", 32'(b_err), 32'h0);
    check("bad_write_no_unlock", 32'({b_lall, b_lock}), 32'hf);
    for (int k = 0; k < 20; k++) step();

    // Reset while locked
    rst = 1'b0;
    step();
    check("midrun_reset_a", 32'(word_a()), 32'h0);
    check("midrun_reset_b", 32'(word_b()), 32'h0);
    rst = 1'b1;
    for (int k = 0; k < 15; k++) step();
    check("relock_wait", 32'(a_lall), 32'h0);
    step();
    check("relock_after_reset", 32'({a_lall, a_lock}), 32'h7);
    cnt0 = 0;
    for (int k = 0; k < 64; k++) begin step(); cnt0 += int'(a_en[0]); end
    // 64 * 43253 / 65536 = 42.24 -> exactly 42 carries from acc=0
    check("default_rate_after_reset", 32'(cnt0), 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
